mem_access: RTL and testbench

Memory-access stage of the five-stage ares RISC-V core. It sits between the EX/M pipeline register and `stage_MW`. It drives the data-memory request/acknowledge bus for loads and stores, aligns load data and sign- or zero-extends it, and selects the write-back value. It produces the `RegWEn_mi`/`AddrD_mi`/`DataD_mi` triple that `stage_MW` registers, and it stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 66 ++++++
 rtl/mem_access_if.sv | 41 ++++
 rtl/mem_access_load_align.sv | 48 ++++
 rtl/mem_access.sv | 173 +++++++++++++++++
 tb/tb_mem_access.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the ares memory-access stage: Funct3
//               load/store widths, write-back selects, FSM states and
//               small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  // Bus widths and reset level.
  localparam int         REG_BUS_W    = 32;
  localparam int         REG_ADDR_W   = 5;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic       RESET_ENABLE = 1'b0;

  // Funct3 load encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Funct3 store encodings.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Write-back source selects.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Access size lives in funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lsb);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = lsb[0];
      default: res = (lsb != 2'b00);
    endcase
    return res;
  endfunction

  // Byte enables for the selected lane(s) of a naturally aligned access.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] lsb);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lsb;
      2'b01:   be = lsb[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Data-memory request/acknowledge bus between the memory-access
//               stage (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if #(
  parameter int XLEN = 32
);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_rdata,
    output dmem_ack
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/halfword lane of a read word and
//               sign- or zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [XLEN-1:0] rdata,
  input  wire logic [1:0]      addr,
  input  wire logic [2:0]      funct3,
  output logic      [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane to a full register value.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access stage of the ares core. Issues registered
//               data-memory requests for loads/stores, stalls the upstream
//               pipeline while a transaction is outstanding, formats load
//               data and selects the write-back value for stage_MW.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  input  wire logic            MemRd_i,
  input  wire logic            MemWr_i,
  input  wire logic [2:0]      Funct3_i,
  input  wire logic [XLEN-1:0] AluRes_i,
  input  wire logic [XLEN-1:0] DataB_i,
  input  wire logic [XLEN-1:0] PcPlus4_i,
  input  wire logic [1:0]      WBSel_i,
  input  wire logic            RegWEn_i,
  input  wire logic [4:0]      AddrD_i,
  output logic                 RegWEn_o,
  output logic      [4:0]      AddrD_o,
  output logic      [XLEN-1:0] DataD_o,
  output logic                 stall_o,
  output logic                 misalign_o,
  mem_access_if.master         dmem
);

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_rdata_q;

  logic            w_mem_op;
  logic            w_misaligned_acc;
  logic            w_stall;
  logic            w_misalign;
  logic            w_bus_load;
  logic            w_bus_clear;
  logic [XLEN-1:0] w_store_data;
  logic [XLEN-1:0] w_load_data;

  assign w_mem_op         = MemRd_i | MemWr_i;
  assign w_misaligned_acc = is_misaligned(Funct3_i[1:0], AluRes_i[1:0]);

  // Replicate store data across every lane it may land in.
  always_comb begin
    case (Funct3_i[1:0])
      2'b00:   w_store_data = {(XLEN/8){DataB_i[7:0]}};
      2'b01:   w_store_data = {(XLEN/16){DataB_i[15:0]}};
      default: w_store_data = DataB_i;
    endcase
  end

  // Transaction state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus stall/misalign and bus load/clear strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_misalign  = 1'b0;
    w_bus_load  = 1'b0;
    w_bus_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          if (w_misaligned_acc) begin
            // Misaligned accesses are flagged and dropped, never issued.
            w_misalign = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_bus_load  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (dmem.dmem_ack) begin
          w_bus_clear = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Result is presented this cycle; the upstream stage advances.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus request registers: loaded on issue, held in WAIT, dropped on ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'b0000;
    end else if (w_bus_load) begin
      r_req   <= 1'b1;
      r_we    <= MemWr_i;
      r_addr  <= {AluRes_i[XLEN-1:2], 2'b00};
      r_wdata <= w_store_data;
      r_be    <= byte_enables(Funct3_i[1:0], AluRes_i[1:0]);
    end else if (w_bus_clear) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
    end
  end

  // Capture read data on the acknowledge so RESP can format it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE) begin
      r_rdata_q <= '0;
    end else if (w_bus_clear) begin
      r_rdata_q <= dmem.dmem_rdata;
    end
  end

  load_align #(
    .XLEN   (XLEN)
  ) u_load_align (
    .rdata  (r_rdata_q),
    .addr   (AluRes_i[1:0]),
    .funct3 (Funct3_i),
    .data   (w_load_data)
  );

  // Write-back value select.
  always_comb begin
    case (WBSel_i)
      WB_ALU:  DataD_o = AluRes_i;
      WB_MEM:  DataD_o = w_load_data;
      WB_PC4:  DataD_o = PcPlus4_i;
      default: DataD_o = AluRes_i;
    endcase
  end

  // Suppress register writes while stalled, on misalignment and for stores.
  assign RegWEn_o   = RegWEn_i & ~w_stall & ~w_misalign & ~MemWr_i;
  assign AddrD_o    = AddrD_i;
  assign stall_o    = w_stall;
  assign misalign_o = w_misalign;

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_be    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  logic        clk_i;
  logic        rst_i;
  logic        MemRd_i;
  logic        MemWr_i;
  logic [2:0]  Funct3_i;
  logic [31:0] AluRes_i;
  logic [31:0] DataB_i;
  logic [31:0] PcPlus4_i;
  logic [1:0]  WBSel_i;
  logic        RegWEn_i;
  logic [4:0]  AddrD_i;
  logic        RegWEn_o;
  logic [4:0]  AddrD_o;
  logic [31:0] DataD_o;
  logic        stall_o;
  logic        misalign_o;

  int checks;
  int errors;
  int stalls;
  int wen_hi;

  mem_access_if #(.XLEN(32)) dmem ();

  mem_access #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRd_i    (MemRd_i),
    .MemWr_i    (MemWr_i),
    .Funct3_i   (Funct3_i),
    .AluRes_i   (AluRes_i),
    .DataB_i    (DataB_i),
    .PcPlus4_i  (PcPlus4_i),
    .WBSel_i    (WBSel_i),
    .RegWEn_i   (RegWEn_i),
    .AddrD_i    (AddrD_i),
    .RegWEn_o   (RegWEn_o),
    .AddrD_o    (AddrD_o),
    .DataD_o    (DataD_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .dmem       (dmem)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] db,
                        input logic [31:0] pc4, input logic [1:0] wb,
                        input logic we, input logic [4:0] ad);
    MemRd_i = mr; MemWr_i = mw; Funct3_i = f3; AluRes_i = alu; DataB_i = db;
    PcPlus4_i = pc4; WBSel_i = wb; RegWEn_i = we; AddrD_i = ad;
  endtask

  // Acts as data memory: acks after ws wait-states, counting stall cycles
  // and any register-write enable seen while stalled. Bounded at 20 cycles.
  task automatic run_mem(input int ws, input logic [31:0] rd,
                         output int n_stall, output int n_wen);
    int wcnt;
    n_stall = 0; n_wen = 0; wcnt = 0;
    dmem.dmem_ack = 1'b0;
    while (stall_o && n_stall < 20) begin
      n_stall++;
      if (RegWEn_o) n_wen++;
      @(posedge clk_i);
      #1;
      if (dmem.dmem_req) begin
        if (wcnt == ws) begin
          dmem.dmem_ack = 1'b1;
          dmem.dmem_rdata = rd;
        end else begin
          dmem.dmem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = 32'hDEAD_BEEF;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i = 1'b0;
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = 32'h0;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0);

    // Reset state.
    #12;
    chk("rst_req",   {31'b0, dmem.dmem_req}, 32'h0);
    chk("rst_we",    {31'b0, dmem.dmem_we}, 32'h0);
    chk("rst_addr",  dmem.dmem_addr, 32'h0);
    chk("rst_wdata", dmem.dmem_wdata, 32'h0);
    chk("rst_be",    {28'b0, dmem.dmem_be}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_misal", {31'b0, misalign_o}, 32'h0);
    set_op(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 2'b01, 1'b1, 5'd3);
    #1;
    chk("rst_misal_comb", {31'b0, misalign_o}, 32'h1);
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // ALU pass-through.
    set_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 2'b00, 1'b1, 5'd5);
    #1;
    chk("alu_data",  DataD_o, 32'h1234);
    chk("alu_wen",   {31'b0, RegWEn_o}, 32'h1);
    chk("alu_addrd", {27'b0, AddrD_o}, 32'd5);
    chk("alu_stall", {31'b0, stall_o}, 32'h0);
    tick();
    chk("alu_req",   {31'b0, dmem.dmem_req}, 32'h0);

    // LB at 0x1003, two wait-states.
    set_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h0, 2'b01, 1'b1, 5'd7);
    #1;
    run_mem(2, 32'h80FF_FF00, stalls, wen_hi);
    chk("lb_stalls", stalls, 32'd4);
    chk("lb_wen_stall", wen_hi, 32'd0);
    chk("lb_data",   DataD_o, 32'hFFFF_FF80);
    chk("lb_wen",    {31'b0, RegWEn_o}, 32'h1);
    chk("lb_req_off", {31'b0, dmem.dmem_req}, 32'h0);
    tick();

    // LBU with identical stimulus.
    set_op(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h0, 2'b01, 1'b1, 5'd7);
    #1;
    run_mem(2, 32'h80FF_FF00, stalls, wen_hi);
    chk("lbu_stalls", stalls, 32'd4);
    chk("lbu_data",  DataD_o, 32'h0000_0080);
    tick();

    // LH at 0x1002 picks the upper half and sign-extends.
    set_op(1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 32'h0, 2'b01, 1'b1, 5'd8);
    #1;
    run_mem(0, 32'h80FF_1234, stalls, wen_hi);
    chk("lh_stalls", stalls, 32'd2);
    chk("lh_data",   DataD_o, 32'hFFFF_80FF);
    tick();

    // SH at 0x2002.
    set_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'hAAAA_BEEF, 32'h0, 2'b00, 1'b1, 5'd0);
    #1;
    chk("sh_wen_idle", {31'b0, RegWEn_o}, 32'h0);
    chk("sh_stall_idle", {31'b0, stall_o}, 32'h1);
    tick();
    chk("sh_req",   {31'b0, dmem.dmem_req}, 32'h1);
    chk("sh_we",    {31'b0, dmem.dmem_we}, 32'h1);
    chk("sh_addr",  dmem.dmem_addr, 32'h2000);
    chk("sh_be",    {28'b0, dmem.dmem_be}, 32'hC);
    chk("sh_wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_wen_wait", {31'b0, RegWEn_o}, 32'h0);
    dmem.dmem_ack = 1'b1;
    tick();
    dmem.dmem_ack = 1'b0;
    chk("sh_stall_resp", {31'b0, stall_o}, 32'h0);
    chk("sh_wen_resp", {31'b0, RegWEn_o}, 32'h0);
    chk("sh_we_clr", {31'b0, dmem.dmem_we}, 32'h0);
    chk("sh_be_clr", {28'b0, dmem.dmem_be}, 32'h0);
    tick();

    // SB at 0x2001.
    set_op(1'b0, 1'b1, 3'b000, 32'h2001, 32'h0000_0055, 32'h0, 2'b00, 1'b0, 5'd0);
    tick();
    chk("sb_be",    {28'b0, dmem.dmem_be}, 32'h2);
    chk("sb_wdata", dmem.dmem_wdata, 32'h5555_5555);
    dmem.dmem_ack = 1'b1;
    tick();
    dmem.dmem_ack = 1'b0;
    tick();

    // Misaligned LW at 0x3001.
    set_op(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 2'b01, 1'b1, 5'd3);
    #1;
    chk("mis_flag",  {31'b0, misalign_o}, 32'h1);
    chk("mis_stall", {31'b0, stall_o}, 32'h0);
    chk("mis_wen",   {31'b0, RegWEn_o}, 32'h0);
    tick();
    chk("mis_noreq", {31'b0, dmem.dmem_req}, 32'h0);
    set_op(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 2'b00, 1'b1, 5'd3);
    #1;
    chk("mis_pulse", {31'b0, misalign_o}, 32'h0);
    tick();

    // Reset asserted while waiting for the ack.
    set_op(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 2'b01, 1'b1, 5'd4);
    tick();
    chk("rw_req_set", {31'b0, dmem.dmem_req}, 32'h1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rw_req_drop", {31'b0, dmem.dmem_req}, 32'h0);
    set_op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 5'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 32'h1234_5678;
    tick();
    tick();
    chk("rw_ack_stall", {31'b0, stall_o}, 32'h0);
    chk("rw_ack_req",   {31'b0, dmem.dmem_req}, 32'h0);
    chk("rw_rdata_q",   DataD_o, 32'h0);
    dmem.dmem_ack = 1'b0;
    tick();

    // JAL followed back-to-back by LW.
    set_op(1'b0, 1'b0, 3'b000, 32'h9999, 32'h0, 32'h84, 2'b10, 1'b1, 5'd1);
    #1;
    chk("jal_data",  DataD_o, 32'h84);
    chk("jal_wen",   {31'b0, RegWEn_o}, 32'h1);
    tick();
    set_op(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 2'b01, 1'b1, 5'd9);
    #1;
    chk("lw_stall_first", {31'b0, stall_o}, 32'h1);
    run_mem(1, 32'hCAFE_F00D, stalls, wen_hi);
    chk("lw_stalls",  stalls, 32'd3);
    chk("lw_wen_stall", wen_hi, 32'd0);
    chk("lw_data",    DataD_o, 32'hCAFE_F00D);
    chk("lw_wen",     {31'b0, RegWEn_o}, 32'h1);
    chk("lw_addrd",   {27'b0, AddrD_o}, 32'd9);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
